// File: rtl/score_review_reader_if.sv
// Handshake and data bundle between the score review reader and its environment
// (game controller, register-file Q port, seven-segment decoders).
interface score_review_reader_if #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 3
);
    logic              Start;
    logic              Skip;
    logic [DATA_W-1:0] RunCount;
    logic [ADDR_W-1:0] ReadQ;
    logic [DATA_W-1:0] DataQ;
    logic [3:0]        Digit0;
    logic [3:0]        Digit1;
    logic [3:0]        Digit2;
    logic [3:0]        Digit3;
    logic [ADDR_W-1:0] Index;
    logic              Valid;
    logic              Busy;
    logic              Done;

    modport master (
        input  Start, Skip, RunCount, DataQ,
        output ReadQ, Digit0, Digit1, Digit2, Digit3, Index, Valid, Busy, Done
    );

    modport slave (
        output Start, Skip, RunCount, DataQ,
        input  ReadQ, Digit0, Digit1, Digit2, Digit3, Index, Valid, Busy, Done
    );
endinterface

// File: rtl/score_review_reader.sv
// Walks stored reaction-time scores, converts each to BCD with a sequential
// double-dabble and holds the result on the score display for a dwell period.
module score_review_reader #(
    parameter int DATA_W     = 13,
    parameter int ADDR_W     = 3,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 3,
    parameter int DWELL      = 2000
) (
    input  logic                  Clock,
    input  logic                  CLRN,
    score_review_reader_if.master bus
);
    localparam int BCD_W   = 16;
    localparam int ITER_W  = $clog2(DATA_W + 1);
    localparam int DWELL_W = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, ADDR, CONVERT, SHOW} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   index_q;
    logic [ADDR_W-1:0]   readq_q;
    logic [DATA_W-1:0]   bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [ITER_W-1:0]   iter_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [BCD_W-1:0]    digits_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W-1:0]       limit_d;
    logic [BCD_W+DATA_W-1:0] step_d;

    // Full-width compare so large run counts saturate instead of aliasing.
    function automatic logic [ADDR_W-1:0] sat_limit(input logic [DATA_W-1:0] cnt);
        if (cnt > DATA_W'(LAST_ADDR))
            return ADDR_W'(LAST_ADDR);
        return cnt[ADDR_W-1:0];
    endfunction

    function automatic logic [BCD_W+DATA_W-1:0] dabble_step(
        input logic [BCD_W-1:0]  bcd,
        input logic [DATA_W-1:0] bin
    );
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (adj[4*n +: 4] >= 4'd5)
                adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
        end
        return {adj, bin} << 1;
    endfunction

    assign limit_d = sat_limit(bus.RunCount);
    assign step_d  = dabble_step(bcd_q, bin_q);

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state_q  <= IDLE;
            index_q  <= '0;
            readq_q  <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            dwell_q  <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    readq_q <= '0;
                    if (bus.Start) begin
                        if (limit_d == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            index_q <= ADDR_W'(FIRST_ADDR);
                            readq_q <= ADDR_W'(FIRST_ADDR);
                            busy_q  <= 1'b1;
                            state_q <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    bin_q   <= bus.DataQ;
                    bcd_q   <= '0;
                    iter_q  <= '0;
                    state_q <= CONVERT;
                end
                CONVERT: begin
                    // One extra cycle after the last shift publishes the settled accumulator.
                    if (iter_q == ITER_W'(DATA_W)) begin
                        digits_q <= bcd_q;
                        valid_q  <= 1'b1;
                        dwell_q  <= '0;
                        state_q  <= SHOW;
                    end else begin
                        {bcd_q, bin_q} <= step_d;
                        iter_q         <= iter_q + ITER_W'(1);
                    end
                end
                SHOW: begin
                    if (bus.Skip || dwell_q == DWELL_W'(DWELL - 1)) begin
                        valid_q <= 1'b0;
                        if (index_q < limit_d) begin
                            index_q <= index_q + ADDR_W'(1);
                            readq_q <= index_q + ADDR_W'(1);
                            state_q <= ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            readq_q <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        dwell_q <= dwell_q + DWELL_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ReadQ  = readq_q;
    assign bus.Index  = index_q;
    assign bus.Digit0 = digits_q[3:0];
    assign bus.Digit1 = digits_q[7:4];
    assign bus.Digit2 = digits_q[11:8];
    assign bus.Digit3 = digits_q[15:12];
    assign bus.Valid  = valid_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
endmodule

// File: tb/tb_score_review_reader.sv
// Bench for score_review_reader: directed and random reviews checked cycle by
// cycle against a timeline model derived from entry count, dwell and skip.
module tb_score_review_reader;
    localparam int DATA_W = 13;
    localparam int ADDR_W = 3;
    localparam int LAST   = 3;
    localparam int DWELL  = 4;
    localparam int CONV   = 15;

    logic              Clock;
    logic              CLRN;
    logic [DATA_W-1:0] regs [8];
    int                n_assert;
    int                n_fail;
    int                shown;

    score_review_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    score_review_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIRST_ADDR(1), .LAST_ADDR(LAST), .DWELL(DWELL)
    ) dut (
        .Clock(Clock),
        .CLRN (CLRN),
        .bus  (bus)
    );

    assign bus.DataQ = regs[bus.ReadQ];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int disp();
        return int'({bus.Digit3, bus.Digit2, bus.Digit1, bus.Digit0});
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_readq"}, int'(bus.ReadQ), 0);
        chk({tag, "_index"}, int'(bus.Index), 0);
        chk({tag, "_digits"}, disp(), 0);
        chk({tag, "_valid"}, int'(bus.Valid), 0);
        chk({tag, "_busy"}, int'(bus.Busy), 0);
        chk({tag, "_done"}, int'(bus.Done), 0);
    endtask

    // Entry k occupies [tk, tk+CONV+show); digits become valid CONV cycles in.
    task automatic run_review(input int rc, input int skip_c, input bit noise, input int abort_at);
        int lim, s, tend, k;
        int tk [4];
        lim = (rc > LAST) ? LAST : rc;
        s = (skip_c != 0 && skip_c < DWELL) ? skip_c : DWELL;
        for (int j = 0; j < 4; j++) tk[j] = j * (CONV + s);
        tend = lim * (CONV + s);
        bus.RunCount = DATA_W'(rc);
        bus.Start = 1'b1;
        bus.Skip = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        for (int t = 0; t <= tend + 2; t++) begin
            k = -1;
            for (int j = 0; j < lim; j++)
                if (t >= tk[j] && t < tk[j] + CONV + s) k = j;
            if (k >= 0 && t == tk[k] + CONV) shown = to_bcd(int'(regs[k + 1]));
            chk("busy", int'(bus.Busy), (k >= 0) ? 1 : 0);
            chk("done", int'(bus.Done), (t == tend) ? 1 : 0);
            chk("valid", int'(bus.Valid), (k >= 0 && t >= tk[k] + CONV) ? 1 : 0);
            chk("readq", int'(bus.ReadQ), (k >= 0) ? k + 1 : 0);
            chk("digits", disp(), shown);
            if (k >= 0) chk("index", int'(bus.Index), k + 1);
            if (t == abort_at) begin
                bus.Start = 1'b0;
                bus.Skip = 1'b0;
                #2 CLRN = 1'b0;
                #1;
                shown = 0;
                chk_all_zero("abort");
                @(negedge Clock);
                CLRN = 1'b1;
                repeat (3) begin
                    @(negedge Clock);
                    chk("post_abort_busy", int'(bus.Busy), 0);
                    chk("post_abort_readq", int'(bus.ReadQ), 0);
                end
                return;
            end
            bus.Start = (noise && t < tend) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k >= 0 && skip_c != 0 && t == tk[k] + CONV - 1 + skip_c)
                bus.Skip = 1'b1;
            else if (k >= 0 && noise && t < tk[k] + CONV)
                bus.Skip = 1'($urandom_range(0, 1));
            else
                bus.Skip = 1'b0;
            @(posedge Clock);
            @(negedge Clock);
        end
        bus.Start = 1'b0;
        bus.Skip = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        shown = 0;
        for (int i = 0; i < 8; i++) regs[i] = '0;
        CLRN = 1'b0;
        bus.Start = 1'b0;
        bus.Skip = 1'b0;
        bus.RunCount = '0;
        repeat (2) @(negedge Clock);
        chk_all_zero("reset");
        CLRN = 1'b1;
        @(negedge Clock);

        // Empty review: immediate Done, nothing shown.
        run_review(0, 0, 1'b0, -1);

        regs[1] = 13'd1234;
        regs[2] = 13'd8191;
        run_review(2, 0, 1'b0, -1);

        regs[1] = 13'd0;
        regs[2] = 13'd5;
        regs[3] = 13'd999;
        regs[4] = 13'd4444;
        run_review(7, 0, 1'b0, -1);
        run_review(8, 0, 1'b0, -1);
        run_review(4096, 0, 1'b0, -1);

        regs[1] = 13'd777;
        run_review(1, 3, 1'b0, -1);

        regs[1] = 13'd4321;
        regs[2] = 13'd10;
        regs[3] = 13'd6000;
        run_review(3, 0, 1'b1, -1);

        // Abort during conversion of the second entry, then a clean restart.
        run_review(3, 0, 1'b0, CONV + DWELL + 5);
        run_review(3, 2, 1'b0, -1);

        for (int it = 0; it < 8; it++) begin
            int rc, sk;
            for (int i = 1; i < 8; i++) regs[i] = DATA_W'($urandom_range(0, 8191));
            rc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 5));
            sk = int'($urandom_range(0, DWELL + 1));
            run_review(rc, sk, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
